// File: rtl/vlan_tag_inserter.sv
// Egress 802.1Q tag inserter: adds TPID 0x8100 + per-tenant TCI after the source MAC and drops disabled tenants.
// Optional macro VLAN_SKIP_TAGGED_EN passes frames whose ethertype is already 0x8100/0x88A8 untouched.
module vlan_tag_inserter #(
   parameter int  AXIS_BUS_WIDTH    = 64,
   parameter int  AXIS_ID_WIDTH     = 4,
   parameter int  AXIS_DEST_WIDTH   = 0,
   parameter int  MAX_PACKET_LENGTH = 1522,
   localparam int EFF_ID_WIDTH      = (AXIS_ID_WIDTH > 0) ? AXIS_ID_WIDTH : 1,
   localparam int EFF_DEST_WIDTH    = (AXIS_DEST_WIDTH > 0) ? AXIS_DEST_WIDTH : 1,
   localparam int KEEP_WIDTH        = AXIS_BUS_WIDTH / 8
) (
   input  logic                      aclk,
   input  logic                      aresetn,
   input  logic [AXIS_BUS_WIDTH-1:0] axis_in_tdata,
   input  logic [EFF_ID_WIDTH-1:0]   axis_in_tid,
   input  logic [EFF_DEST_WIDTH-1:0] axis_in_tdest,
   input  logic [KEEP_WIDTH-1:0]     axis_in_tkeep,
   input  logic                      axis_in_tlast,
   input  logic                      axis_in_tvalid,
   output logic                      axis_in_tready,
   output logic [AXIS_BUS_WIDTH-1:0] axis_out_tdata,
   output logic [EFF_ID_WIDTH-1:0]   axis_out_tid,
   output logic [EFF_DEST_WIDTH-1:0] axis_out_tdest,
   output logic [KEEP_WIDTH-1:0]     axis_out_tkeep,
   output logic                      axis_out_tlast,
   output logic                      axis_out_tvalid,
   input  logic                      axis_out_tready,
   output logic [EFF_ID_WIDTH-1:0]   vlan_config_sel,
   input  logic [17:0]               vlan_config_regs
);

   localparam int CNT_W    = $clog2(MAX_PACKET_LENGTH + 1);
   localparam int INS_BYTE = (12 / KEEP_WIDTH) * KEEP_WIDTH;
   localparam int OFF      = 12 % KEEP_WIDTH;
   localparam logic [AXIS_BUS_WIDTH-1:0] LO_DMASK =
      (OFF == 0) ? '0 : ({AXIS_BUS_WIDTH{1'b1}} >> (AXIS_BUS_WIDTH - OFF * 8));

   typedef enum logic [2:0] {
      ST_HEAD, ST_PRE, ST_INS, ST_SHIFT, ST_PASS, ST_EXTRA, ST_DROP
   } state_t;

   function automatic logic [31:0] keep_count(input logic [KEEP_WIDTH-1:0] k);
      keep_count = 32'd0;
      for (int i = 0; i < KEEP_WIDTH; i++) begin
         keep_count = keep_count + {31'd0, k[i]};
      end
   endfunction

   function automatic logic [KEEP_WIDTH-1:0] low_mask(input logic [31:0] n);
      for (int i = 0; i < KEEP_WIDTH; i++) begin
         low_mask[i] = (32'(i) < n);
      end
   endfunction

   state_t                    state_q, state_d;
   logic [CNT_W-1:0]          cnt_q, cnt_d;
   logic [31:0]               carry_q, carry_d;
   logic [KEEP_WIDTH-1:0]     xkeep_q, xkeep_d;
   logic [17:0]               cfg_q, cfg_d;
   logic [EFF_ID_WIDTH-1:0]   tid_q, tid_d;
   logic [EFF_DEST_WIDTH-1:0] dest_q, dest_d;
   logic                      run_q;

   logic [AXIS_BUS_WIDTH-1:0] out_data_q;
   logic [EFF_ID_WIDTH-1:0]   out_tid_q;
   logic [EFF_DEST_WIDTH-1:0] out_dest_q;
   logic [KEEP_WIDTH-1:0]     out_keep_q;
   logic                      out_last_q;
   logic                      out_valid_q;

   logic                      advance_s, fire_s, sop_s, at_ins_s, runt_s, skip_s;
   logic                      emit_s, tail_s;
   logic [17:0]               cfg_s;
   logic [EFF_ID_WIDTH-1:0]   cur_tid_s;
   logic [EFF_DEST_WIDTH-1:0] cur_dest_s;
   logic [31:0]               nvalid_s, total_s, tag32_s, top_s;
   logic [AXIS_BUS_WIDTH-1:0] ins_data_s, shift_data_s, beat_data_s;
   logic [KEEP_WIDTH-1:0]     beat_keep_s;
   logic                      beat_last_s;

   assign advance_s      = !out_valid_q || axis_out_tready;
   assign axis_in_tready = run_q && ((state_q == ST_DROP) || (advance_s && (state_q != ST_EXTRA)));
   assign fire_s         = axis_in_tvalid && axis_in_tready;
   assign sop_s          = (state_q == ST_HEAD);
   assign at_ins_s       = (state_q == ST_INS) || (sop_s && (INS_BYTE == 0));
   assign vlan_config_sel = axis_in_tid;

   // Config and stream sideband are taken live on the SOP beat, from the latched copy afterwards
   assign cfg_s      = sop_s ? vlan_config_regs : cfg_q;
   assign cur_tid_s  = sop_s ? axis_in_tid : tid_q;
   assign cur_dest_s = sop_s ? axis_in_tdest : dest_q;

   assign nvalid_s = keep_count(axis_in_tkeep);
   assign total_s  = 32'(cnt_q) + nvalid_s;
   assign runt_s   = axis_in_tlast && (total_s < 32'd14);

   assign tag32_s      = {cfg_s[7:0], cfg_s[15:8], 8'h00, 8'h81};
   assign top_s        = axis_in_tdata[AXIS_BUS_WIDTH-1 -: 32];
   assign ins_data_s   = (axis_in_tdata & LO_DMASK)
                       | (AXIS_BUS_WIDTH'(tag32_s) << (OFF * 8))
                       | ((axis_in_tdata & ~LO_DMASK) << 32);
   assign shift_data_s = (axis_in_tdata << 32) | AXIS_BUS_WIDTH'(carry_q);

`ifdef VLAN_SKIP_TAGGED_EN
   assign skip_s = ({axis_in_tdata[OFF*8 +: 8], axis_in_tdata[(OFF+1)*8 +: 8]} == 16'h8100)
                || ({axis_in_tdata[OFF*8 +: 8], axis_in_tdata[(OFF+1)*8 +: 8]} == 16'h88A8);
`else
   assign skip_s = 1'b0;
`endif

   // Next-state and output-beat construction
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      carry_d     = carry_q;
      xkeep_d     = xkeep_q;
      cfg_d       = cfg_q;
      tid_d       = tid_q;
      dest_d      = dest_q;
      emit_s      = 1'b0;
      tail_s      = 1'b0;
      beat_data_s = axis_in_tdata;
      beat_keep_s = axis_in_tkeep;
      beat_last_s = axis_in_tlast;
      if (fire_s) begin
         if (sop_s) begin
            cfg_d  = vlan_config_regs;
            tid_d  = axis_in_tid;
            dest_d = axis_in_tdest;
         end else begin
            cfg_d  = cfg_q;
         end
         if (axis_in_tlast) begin
            cnt_d = '0;
         end else if (total_s >= 32'(MAX_PACKET_LENGTH)) begin
            cnt_d = CNT_W'(MAX_PACKET_LENGTH);
         end else begin
            cnt_d = CNT_W'(total_s);
         end
         case (state_q)
            ST_HEAD, ST_PRE, ST_INS: begin
               if (sop_s && !cfg_s[17]) begin
                  state_d = axis_in_tlast ? ST_HEAD : ST_DROP;
               end else if (at_ins_s) begin
                  emit_s = 1'b1;
                  if (runt_s || skip_s || !cfg_s[16]) begin
                     state_d = axis_in_tlast ? ST_HEAD : ST_PASS;
                  end else begin
                     beat_data_s = ins_data_s;
                     carry_d     = top_s;
                     tail_s      = 1'b1;
                  end
               end else begin
                  emit_s = 1'b1;
                  if (axis_in_tlast) begin
                     state_d = ST_HEAD;
                  end else if (32'(cnt_q) + 32'(KEEP_WIDTH) == 32'(INS_BYTE)) begin
                     state_d = ST_INS;
                  end else begin
                     state_d = ST_PRE;
                  end
               end
            end
            ST_SHIFT: begin
               emit_s      = 1'b1;
               beat_data_s = shift_data_s;
               carry_d     = top_s;
               tail_s      = 1'b1;
            end
            ST_PASS: begin
               emit_s  = 1'b1;
               state_d = axis_in_tlast ? ST_HEAD : ST_PASS;
            end
            ST_DROP: begin
               state_d = axis_in_tlast ? ST_HEAD : ST_DROP;
            end
            ST_EXTRA: begin
               state_d = state_q;
            end
            default: begin
               state_d = ST_HEAD;
            end
         endcase
         // A tagged beat grows by 4 bytes; overflow past the bus spills into one extra beat
         if (tail_s) begin
            if (!axis_in_tlast) begin
               beat_keep_s = '1;
               beat_last_s = 1'b0;
               state_d     = ST_SHIFT;
            end else if (nvalid_s <= 32'(KEEP_WIDTH - 4)) begin
               beat_keep_s = low_mask(nvalid_s + 32'd4);
               beat_last_s = 1'b1;
               state_d     = ST_HEAD;
            end else begin
               beat_keep_s = '1;
               beat_last_s = 1'b0;
               xkeep_d     = low_mask(nvalid_s - 32'(KEEP_WIDTH - 4));
               state_d     = ST_EXTRA;
            end
         end else begin
            xkeep_d = xkeep_q;
         end
      end else if ((state_q == ST_EXTRA) && advance_s) begin
         emit_s      = 1'b1;
         beat_data_s = AXIS_BUS_WIDTH'(carry_q);
         beat_keep_s = xkeep_q;
         beat_last_s = 1'b1;
         state_d     = ST_HEAD;
      end else begin
         state_d = state_q;
      end
   end

   // Frame state, byte counter and per-frame latches
   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         state_q <= ST_HEAD;
         cnt_q   <= '0;
         carry_q <= 32'd0;
         xkeep_q <= '0;
         cfg_q   <= 18'd0;
         tid_q   <= '0;
         dest_q  <= '0;
         run_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         carry_q <= carry_d;
         xkeep_q <= xkeep_d;
         cfg_q   <= cfg_d;
         tid_q   <= tid_d;
         dest_q  <= dest_d;
         run_q   <= 1'b1;
      end
   end

   // Single-register output stage
   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         out_keep_q  <= '0;
         out_last_q  <= 1'b0;
         out_tid_q   <= '0;
         out_dest_q  <= '0;
      end else if (advance_s) begin
         out_valid_q <= emit_s;
         if (emit_s) begin
            out_data_q <= beat_data_s;
            out_keep_q <= beat_keep_s;
            out_last_q <= beat_last_s;
            out_tid_q  <= cur_tid_s;
            out_dest_q <= cur_dest_s;
         end
      end
   end

   assign axis_out_tdata  = out_data_q;
   assign axis_out_tkeep  = out_keep_q;
   assign axis_out_tlast  = out_last_q;
   assign axis_out_tvalid = out_valid_q;
   assign axis_out_tid    = out_tid_q;
   assign axis_out_tdest  = out_dest_q;

endmodule

// File: tb/tb_vlan_tag_inserter.sv
// Scoreboard bench for vlan_tag_inserter (64-bit bus): directed frames, expected beats queued by the driver.
module tb_vlan_tag_inserter;

   logic        aclk = 1'b0;
   logic        aresetn;
   logic [63:0] axis_in_tdata;
   logic [3:0]  axis_in_tid;
   logic [0:0]  axis_in_tdest;
   logic [7:0]  axis_in_tkeep;
   logic        axis_in_tlast, axis_in_tvalid, axis_in_tready;
   logic [63:0] axis_out_tdata;
   logic [3:0]  axis_out_tid;
   logic [0:0]  axis_out_tdest;
   logic [7:0]  axis_out_tkeep;
   logic        axis_out_tlast, axis_out_tvalid, axis_out_tready;
   logic [3:0]  vlan_config_sel;
   logic [17:0] vlan_config_regs;

   vlan_tag_inserter #(.AXIS_BUS_WIDTH(64), .AXIS_ID_WIDTH(4), .AXIS_DEST_WIDTH(0),
                       .MAX_PACKET_LENGTH(1522)) dut (
      .aclk(aclk), .aresetn(aresetn),
      .axis_in_tdata(axis_in_tdata), .axis_in_tid(axis_in_tid), .axis_in_tdest(axis_in_tdest),
      .axis_in_tkeep(axis_in_tkeep), .axis_in_tlast(axis_in_tlast), .axis_in_tvalid(axis_in_tvalid),
      .axis_in_tready(axis_in_tready),
      .axis_out_tdata(axis_out_tdata), .axis_out_tid(axis_out_tid), .axis_out_tdest(axis_out_tdest),
      .axis_out_tkeep(axis_out_tkeep), .axis_out_tlast(axis_out_tlast),
      .axis_out_tvalid(axis_out_tvalid), .axis_out_tready(axis_out_tready),
      .vlan_config_sel(vlan_config_sel), .vlan_config_regs(vlan_config_regs)
   );

   always #5 aclk = ~aclk;

   typedef struct {
      logic [63:0] data;
      logic [7:0]  keep;
      logic        last;
      logic [3:0]  tid;
      logic        dest;
   } beat_t;

   beat_t       exp_q[$];
   logic [63:0] cap_q[$];
   int          checks = 0;
   int          errors = 0;
   int          out_beats = 0;
   logic        sb_ignore = 1'b0;
   logic        throttle = 1'b0;
   logic        drop_chk = 1'b0;

   function automatic logic [63:0] byte_mask(input logic [7:0] k);
      for (int i = 0; i < 8; i++) byte_mask[i*8 +: 8] = {8{k[i]}};
   endfunction

   task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
      checks++;
      if (got !== want) begin
         errors++;
         $display("FAIL %s: got %h, wanted %h", name, got, want);
      end
   endtask

   // Output-side throttling, changed on the falling edge
   initial begin
      axis_out_tready = 1'b1;
      forever begin
         @(negedge aclk);
         axis_out_tready = throttle ? 1'($urandom_range(0, 1)) : 1'b1;
      end
   end

   // Monitor: compares every accepted output beat with the head of the scoreboard
   initial begin
      beat_t e;
      forever begin
         @(negedge aclk); #1;
         if (aresetn && axis_out_tvalid && axis_out_tready) begin
            out_beats++;
            cap_q.push_back(axis_out_tdata);
            if (!sb_ignore) begin
               checks++;
               if (exp_q.size() == 0) begin
                  errors++;
                  $display("FAIL unexpected_beat: got data=%h keep=%h last=%b, wanted no beat",
                           axis_out_tdata, axis_out_tkeep, axis_out_tlast);
               end else begin
                  e = exp_q.pop_front();
                  if (((axis_out_tdata & byte_mask(e.keep)) !== e.data) || (axis_out_tkeep !== e.keep) ||
                      (axis_out_tlast !== e.last) || (axis_out_tid !== e.tid) || (axis_out_tdest !== e.dest)) begin
                     errors++;
                     $display("FAIL out_beat: got data=%h keep=%h last=%b tid=%h dest=%b, wanted data=%h keep=%h last=%b tid=%h dest=%b",
                              axis_out_tdata & byte_mask(e.keep), axis_out_tkeep, axis_out_tlast, axis_out_tid,
                              axis_out_tdest, e.data, e.keep, e.last, e.tid, e.dest);
                  end
               end
            end
         end
      end
   end

   task automatic wait_ready();
      int n = 0;
      while (!axis_in_tready && n < 1000) begin
         @(negedge aclk); #1;
         n++;
      end
      if (n >= 1000) check("in_tready_timeout", 64'(axis_in_tready), 64'd1);
   endtask

   task automatic wait_drain();
      int n = 0;
      while (exp_q.size() != 0 && n < 2000) begin
         @(negedge aclk); #1;
         n++;
      end
      repeat (4) begin @(negedge aclk); #1; end
      check("scoreboard_drained", 64'(exp_q.size()), 64'd0);
   endtask

   // Builds the expected byte stream, queues the expected beats, then drives the frame
   task automatic send_frame(input int len, input logic [3:0] tid, input logic [17:0] cfg,
                             input logic [7:0] seed, input logic ovr, input logic [15:0] et,
                             input logic chk_extra);
      logic [7:0] fb[$];
      logic [7:0] ob[$];
      beat_t      b;
      logic       tagit;
      int         nbeats;
      for (int i = 0; i < len; i++) fb.push_back(seed + 8'(i));
      if (ovr) begin
         fb[12] = et[15:8];
         fb[13] = et[7:0];
      end
      if (cfg[17]) begin
         tagit = cfg[16] && (len >= 14);
`ifdef VLAN_SKIP_TAGGED_EN
         if (len >= 14 && ({fb[12], fb[13]} == 16'h8100 || {fb[12], fb[13]} == 16'h88A8)) tagit = 1'b0;
`endif
         for (int i = 0; i < len; i++) begin
            if (tagit && i == 12) begin
               ob.push_back(8'h81);
               ob.push_back(8'h00);
               ob.push_back(cfg[15:8]);
               ob.push_back(cfg[7:0]);
            end
            ob.push_back(fb[i]);
         end
      end
      for (int i = 0; i < ob.size(); i += 8) begin
         b.data = 64'd0;
         b.keep = 8'd0;
         for (int j = 0; j < 8 && i + j < ob.size(); j++) begin
            b.data[j*8 +: 8] = ob[i+j];
            b.keep[j] = 1'b1;
         end
         b.last = (i + 8 >= ob.size());
         b.tid  = tid;
         b.dest = tid[0];
         exp_q.push_back(b);
      end
      vlan_config_regs = cfg;
      nbeats = (len + 7) / 8;
      for (int k = 0; k < nbeats; k++) begin
         axis_in_tvalid = 1'b1;
         axis_in_tdata  = 64'd0;
         axis_in_tkeep  = 8'd0;
         for (int j = 0; j < 8; j++) begin
            if (k * 8 + j < len) begin
               axis_in_tdata[j*8 +: 8] = fb[k*8+j];
               axis_in_tkeep[j] = 1'b1;
            end
         end
         axis_in_tlast = (k == nbeats - 1);
         axis_in_tid   = (k == 0) ? tid : ~tid;
         axis_in_tdest = (k == 0) ? tid[0] : ~tid[0];
         if (drop_chk) check("drop_in_tready", 64'(axis_in_tready), 64'd1);
         wait_ready();
         @(negedge aclk); #1;
         vlan_config_regs = ~cfg;
      end
      axis_in_tvalid = 1'b0;
      axis_in_tlast  = 1'b0;
      if (chk_extra) check("extra_in_tready", 64'(axis_in_tready), 64'd0);
   endtask

   initial begin
      int base;
      aresetn          = 1'b0;
      axis_in_tdata    = 64'd0;
      axis_in_tid      = 4'd0;
      axis_in_tdest    = 1'b0;
      axis_in_tkeep    = 8'd0;
      axis_in_tlast    = 1'b0;
      axis_in_tvalid   = 1'b0;
      vlan_config_regs = 18'd0;
      repeat (3) @(negedge aclk);
      #1;
      check("rst_out_tvalid", 64'(axis_out_tvalid), 64'd0);
      check("rst_out_tkeep", 64'(axis_out_tkeep), 64'd0);
      check("rst_out_tdata", axis_out_tdata, 64'd0);
      check("rst_in_tready", 64'(axis_in_tready), 64'd0);
      aresetn = 1'b1;
      repeat (2) @(negedge aclk);
      #1;
      check("post_rst_in_tready", 64'(axis_in_tready), 64'd1);

      // 64-byte tagged frame
      base = out_beats; cap_q.delete();
      send_frame(64, 4'd2, 18'h3_6005, 8'h00, 1'b0, 16'h0000, 1'b0);
      wait_drain();
      check("t64_beats", 64'(out_beats - base), 64'd9);
      check("t64_beat1", cap_q[1], 64'h0560_0081_0b0a_0908);
      check("t64_beat2", cap_q[2], 64'h1312_1110_0f0e_0d0c);

      // 60-byte: fits without an extra beat; 62-byte: needs one
      base = out_beats;
      send_frame(60, 4'd3, 18'h3_A00B, 8'h40, 1'b0, 16'h0000, 1'b0);
      wait_drain();
      check("t60_beats", 64'(out_beats - base), 64'd8);
      base = out_beats;
      send_frame(62, 4'd4, 18'h3_1234, 8'h80, 1'b0, 16'h0000, 1'b1);
      wait_drain();
      check("t62_beats", 64'(out_beats - base), 64'd9);

      // Disabled tenant: three dropped frames plus a single-beat one, then an enabled frame
      base = out_beats;
      drop_chk = 1'b1;
      repeat (3) send_frame(64, 4'd5, 18'h1_0123, 8'h10, 1'b0, 16'h0000, 1'b0);
      send_frame(8, 4'd5, 18'h0_0123, 8'h10, 1'b0, 16'h0000, 1'b0);
      drop_chk = 1'b0;
      wait_drain();
      check("drop_beats", 64'(out_beats - base), 64'd0);
      base = out_beats;
      send_frame(64, 4'd5, 18'h3_0123, 8'h20, 1'b0, 16'h0000, 1'b0);
      wait_drain();
      check("after_drop_beats", 64'(out_beats - base), 64'd9);

      // Throttled output: runts, tag_en=0, length boundaries
      throttle = 1'b1;
      base = out_beats;
      send_frame(10, 4'd1, 18'h3_0FFF, 8'h30, 1'b0, 16'h0000, 1'b0);
      send_frame(40, 4'd6, 18'h2_0FFF, 8'h50, 1'b0, 16'h0000, 1'b0);
      send_frame(13, 4'd7, 18'h3_E001, 8'h60, 1'b0, 16'h0000, 1'b0);
      send_frame(14, 4'd8, 18'h3_E002, 8'h70, 1'b0, 16'h0000, 1'b0);
      send_frame(64, 4'd9, 18'h3_4321, 8'h90, 1'b0, 16'h0000, 1'b0);
      wait_drain();
      throttle = 1'b0;
      check("throttle_beats", 64'(out_beats - base), 64'd21);

      // Reset in the middle of a frame
      sb_ignore = 1'b1;
      vlan_config_regs = 18'h3_6005;
      for (int k = 0; k < 5; k++) begin
         axis_in_tvalid = 1'b1;
         axis_in_tdata  = 64'(k) * 64'h0101_0101_0101_0101;
         axis_in_tkeep  = 8'hFF;
         axis_in_tlast  = 1'b0;
         axis_in_tid    = 4'd2;
         if (k < 4) begin
            wait_ready();
            @(negedge aclk); #1;
         end
      end
      aresetn = 1'b0;
      #1;
      check("midrst_out_tvalid", 64'(axis_out_tvalid), 64'd0);
      check("midrst_in_tready", 64'(axis_in_tready), 64'd0);
      axis_in_tvalid = 1'b0;
      repeat (2) @(negedge aclk);
      #1;
      aresetn = 1'b1;
      exp_q.delete();
      repeat (2) @(negedge aclk);
      #1;
      sb_ignore = 1'b0;
      base = out_beats;
      send_frame(64, 4'd2, 18'h3_6005, 8'h00, 1'b0, 16'h0000, 1'b0);
      wait_drain();
      check("post_midrst_beats", 64'(out_beats - base), 64'd9);

      // Frames whose ethertype is already a VLAN TPID
      base = out_beats;
      send_frame(64, 4'd3, 18'h3_7007, 8'h11, 1'b1, 16'h8100, 1'b0);
      send_frame(64, 4'd3, 18'h3_7007, 8'h22, 1'b1, 16'h88A8, 1'b0);
      wait_drain();
`ifdef VLAN_SKIP_TAGGED_EN
      check("pretagged_beats", 64'(out_beats - base), 64'd16);
`else
      check("pretagged_beats", 64'(out_beats - base), 64'd18);
`endif

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/vlan_tag_inserter.md
Name: vlan_tag_inserter

Overview:
- Egress-side counterpart of the ingress VLAN parser in the full NMU.
- Inserts an 802.1Q tag (TPID 0x8100 plus a per-tenant TCI) after the source MAC (byte offset 12) of every frame leaving a tenant.
- Per-tenant config is selected by AXIS tid.
- Also drops frames from tenants whose egress is disabled.
- Sits between the tenant-side egress AXIS mux and the MAC-side egress path.

Parameters:
- AXIS_BUS_WIDTH, 64, data bus width in bits. Legal values: 32, 64, 128, 256, 512.
- AXIS_ID_WIDTH, 4, tid width (tenant index). Effective width is max(1, value).
- AXIS_DEST_WIDTH, 0, tdest width. Effective width is max(1, value); passed through unchanged.
- MAX_PACKET_LENGTH, 1522, maximum output frame length in bytes. Sizes the internal byte counter.

Ports:
- aclk  in  1  clock
- aresetn  in  1  asynchronous active-low reset
- axis_in_tdata  in  AXIS_BUS_WIDTH  untagged frame data; byte 0 in bits [7:0]
- axis_in_tid  in  EFF_ID_WIDTH  tenant index
- axis_in_tdest  in  EFF_DEST_WIDTH  passthrough
- axis_in_tkeep  in  AXIS_BUS_WIDTH/8  contiguous from LSB; all ones except on the tlast beat
- axis_in_tlast, axis_in_tvalid  in  1 each
- axis_in_tready  out  1
- axis_out_tdata, axis_out_tid, axis_out_tdest, axis_out_tkeep, axis_out_tlast, axis_out_tvalid  out  widths as input
- axis_out_tready  in  1
- vlan_config_sel  out  EFF_ID_WIDTH  equals axis_in_tid (combinational)
- vlan_config_regs  in  18  [15:0] TCI (PCP/DEI/VID), [16] tag_en, [17] tx_en

Behaviour:
- Reset (async, aresetn=0) forces:
  - axis_out_tvalid=0, axis_out_tlast=0, axis_out_tkeep=0, axis_out_tdata=0, tid=0, tdest=0
  - axis_in_tready=0; state=HEAD; byte counter=0
  - After release, tready follows the pipeline rule on the first clock.
- Output stage is a single register:
  - Latency is 1 cycle when unstalled.
  - axis_in_tready = (!out_valid || axis_out_tready) && state!=EXTRA; in DROP it is 1.
- Decision point: config is latched on the first beat (SOP) of each frame. tid/tdest are latched at SOP and held for the whole frame.
- Insertion beat = beat holding byte 12: index 12/NB, offset 12%NB, where NB = bytes per beat.
- States:
  - HEAD (SOP beat):
    - tx_en=0 → DROP.
    - Otherwise, if the SOP beat is the insertion beat, handle it as in INS.
    - Otherwise → PRE.
    - tx_en=0 and tlast together → return to HEAD, nothing output.
  - PRE: beats before the insertion beat pass unmodified. On reaching the insertion beat → INS.
  - INS:
    - tag_en=1: output bytes [0..off-1] unchanged, then 0x81, 0x00, TCI[15:8], TCI[7:0]; remaining input bytes are shifted up 4 positions.
    - The top 4 displaced bytes go into the carry register.
    - tag_en=0 → PASS (no insertion).
  - SHIFT: each output beat = {input[NB-5:0] bytes, carry[3:0]}; carry updated from input top 4 bytes.
  - PASS: unmodified passthrough until tlast.
  - EXTRA: entered when a tlast beat carries more than NB-4 valid bytes.
    - Emits one extra beat of the carry bytes with tkeep = (1<<(valid-(NB-4)))-1 and tlast=1.
    - Input is stalled during this beat.
  - DROP: consume beats with tready=1, no output, until tlast → HEAD.
- Last-beat tkeep: if valid bytes are ≤ NB-4, out tkeep = (1<<(valid+4))-1, tlast on the same beat, no EXTRA.
- Runt frame: tlast arrives before byte 13 is received (frame < 14 bytes).
  - The frame is forwarded unmodified; no tag is inserted.
  - Runt check uses the byte counter (counts input bytes, saturates at MAX_PACKET_LENGTH).
- Frames already at MAX_PACKET_LENGTH-4 or above are still tagged. Truncation is upstream's responsibility.
- Config changes mid-frame are ignored until the next SOP.

Optional Feature:
- Macro: VLAN_SKIP_TAGGED_EN.
- Defined: in INS, if input bytes 12-13 equal 0x8100 or 0x88A8, no tag is inserted and the frame goes → PASS. An already-tagged tenant frame is never double-tagged. tx_en drop still applies.
- Undefined: the tag is always inserted when tag_en=1, regardless of the existing ethertype.

Test Plan:
- 64-bit bus, tid=2, TCI=0x6005, tag_en=1, tx_en=1, 64-byte frame (8 beats) → 9 output beats:
  - bytes 12..15 = 81 00 60 05, output byte 16 = input byte 12
  - last tkeep=0x0F, tid=2 on every beat
- 60-byte frame, last in tkeep=0x0F → 8 output beats, last tkeep=0xFF, no EXTRA.
- 62-byte frame, last tkeep=0x3F → 9 output beats, extra beat tkeep=0x03, tlast only on the extra beat. Check in_tready=0 during EXTRA.
- tx_en=0, 3 back-to-back 64-byte frames → zero output beats, in_tready=1 throughout. Following frame with tx_en=1 is tagged correctly.
- 10-byte runt (1 beat plus 2 bytes) and tag_en=0 frames → output byte-identical to input. Random axis_out_tready throttling (50%) loses and duplicates no data.
- aresetn asserted mid-frame (beat 4) → out_tvalid=0 immediately. The next frame is tagged correctly from SOP. With VLAN_SKIP_TAGGED_EN, an input with bytes 12-13 = 81 00 is output unchanged.
